// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and the queue entry payload for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

    localparam int unsigned     XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-memory, redirect and decode-side signals of the prefetch queue.
// PREFETCH_PERF_EN adds the two performance counter outputs.
interface instr_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import instr_prefetch_queue_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic [CW-1:0]   occupancy;
`ifdef PREFETCH_PERF_EN
    logic [31:0]     perf_stall_cycles;
    logic [31:0]     perf_flushes;

    modport master (
        input  imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, occupancy,
        output perf_stall_cycles, perf_flushes
    );
    modport slave (
        output imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, occupancy,
        input  perf_stall_cycles, perf_flushes
    );
`else
    modport master (
        input  imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, occupancy
    );
    modport slave (
        output imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, occupancy
    );
`endif

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// DEPTH-entry {pc, instr} FIFO with push/pop/clear and a registered head.
// Reset clears pointers, count and head; the storage array is left as is.
module instr_prefetch_queue_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  entry_t                   wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output entry_t                   head,
    output logic                     head_ld_c,
    output logic [XLEN-1:0]          head_pc_nxt_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt_c;
    logic [CW-1:0] remain_c;
    logic [CW-1:0] count_nxt_c;
    entry_t        head_nxt_c;

    // Next head: the entry being written bypasses the array when nothing older remains.
    always_comb begin
        remain_c     = count - CW'(pop);
        count_nxt_c  = remain_c + CW'(push);
        rd_ptr_nxt_c = rd_ptr + PW'(pop);
        head_ld_c    = 1'b0;
        head_nxt_c   = head;
        if (clear) begin
            count_nxt_c  = '0;
            rd_ptr_nxt_c = '0;
        end else if (count_nxt_c != '0) begin
            head_ld_c  = 1'b1;
            head_nxt_c = (remain_c == '0) ? wdata : mem[rd_ptr_nxt_c];
        end
    end

    assign head_pc_nxt_c = head_nxt_c.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt_c;
            wr_ptr     <= clear ? '0 : wr_ptr + PW'(push);
            count      <= count_nxt_c;
            head_valid <= (count_nxt_c != '0);
            if (head_ld_c) begin
                head <= head_nxt_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side instruction prefetch queue: owns fetch PC, buffers fetched words, flushes on redirect.
// Optional PREFETCH_PERF_EN adds saturating stall and flush counters.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_prefetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_plus4;
    logic [CW-1:0]   count;
    logic            head_valid;
    entry_t          head;
    entry_t          wdata_c;
    logic            head_ld_c;
    logic [XLEN-1:0] head_pc_nxt_c;
    logic            deq_c;
    logic            enq_c;

    // A redirect blocks the fetch of its own cycle; a full queue fetches only alongside a dequeue.
    assign deq_c        = head_valid & bus.out_ready;
    assign enq_c        = ~bus.redirect_valid & ((count < CW'(DEPTH)) | deq_c);
    assign wdata_c.pc    = fetch_pc;
    assign wdata_c.instr = bus.imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pc_plus4 <= '0;
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end else if (enq_c) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (head_ld_c) begin
                pc_plus4 <= head_pc_nxt_c + PC_STEP;
            end
        end
    end

    instr_prefetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst),
        .push          (enq_c),
        .pop           (deq_c),
        .clear         (bus.redirect_valid),
        .wdata         (wdata_c),
        .count         (count),
        .head_valid    (head_valid),
        .head          (head),
        .head_ld_c     (head_ld_c),
        .head_pc_nxt_c (head_pc_nxt_c)
    );

    assign bus.imem_addr    = fetch_pc;
    assign bus.out_valid    = head_valid;
    assign bus.out_instr    = head.instr;
    assign bus.out_pc       = head.pc;
    assign bus.out_pc_plus4 = pc_plus4;
    assign bus.occupancy    = count;

`ifdef PREFETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (head_valid & ~bus.out_ready & (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bus.redirect_valid & (count != '0) & (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cycles = stall_cnt;
    assign bus.perf_flushes      = flush_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: queue-based reference model checked every cycle plus directed literals.
module tb_instr_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic seen200  = 1'b0;

    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = bus.imem_addr ^ XORK;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, instr} plus the last head shown.
    logic [63:0] mq[$];
    logic [31:0] m_fpc   = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_plus4 = 32'h0;
    logic        m_deq;
    logic [31:0] m_stall = 32'h0;
    logic [31:0] m_flush = 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_fpc   = 32'h0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_plus4 = 32'h0;
            m_stall = 32'h0;
            m_flush = 32'h0;
        end else begin
            m_deq = (mq.size() != 0) && bus.out_ready;
            if ((mq.size() != 0) && !bus.out_ready) m_stall = m_stall + 32'd1;
            if (bus.redirect_valid && (mq.size() != 0)) m_flush = m_flush + 32'd1;
            if (bus.redirect_valid) begin
                mq.delete();
                m_fpc = bus.redirect_pc;
            end else begin
                if (m_deq) void'(mq.pop_front());
                if (mq.size() < DEPTH) begin
                    mq.push_back({m_fpc, m_fpc ^ XORK});
                    m_fpc = m_fpc + 32'd4;
                end
            end
            if (mq.size() != 0) begin
                m_pc    = mq[0][63:32];
                m_instr = mq[0][31:0];
                m_plus4 = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        check("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        check("imem_addr", bus.imem_addr, m_fpc);
        check("out_pc", bus.out_pc, m_pc);
        check("out_instr", bus.out_instr, m_instr);
        check("out_pc_plus4", bus.out_pc_plus4, m_plus4);
`ifdef PREFETCH_PERF_EN
        check("perf_stall", bus.perf_stall_cycles, m_stall);
        check("perf_flush", bus.perf_flushes, m_flush);
`endif
        if (bus.out_valid && bus.out_pc == 32'h200) seen200 = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst                = 1'b0;
        bus.out_ready      = rdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst                = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_occ", 32'(bus.occupancy), 32'h0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_plus4", bus.out_pc_plus4, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);

        // Streaming with decode always ready
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", 32'(bus.out_valid), 32'h1);
            check("t1_pc", bus.out_pc, 32'(4 * i));
            check("t1_plus4", bus.out_pc_plus4, 32'(4 * i + 4));
            check("t1_instr", bus.out_instr, 32'(4 * i) ^ XORK);
        end

        // Stall for 8 cycles, then drain
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t2_occ", 32'(bus.occupancy), 32'((k < 4) ? k : 4));
            check("t2_addr", bus.imem_addr, 32'(4 * ((k < 4) ? k : 4)));
            check("t2_head", bus.out_pc, 32'h0);
        end
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("t2_drain", bus.out_pc, 32'(4 * j));
        end

        // Full queue with a single-cycle dequeue
        do_reset(1'b0);
        repeat (5) tick();
        check("t3_full", 32'(bus.occupancy), 32'h4);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_occ", 32'(bus.occupancy), 32'h4);
        check("t3_head", bus.out_pc, 32'h4);
        tick();
        check("t3_stable", bus.out_pc, 32'h4);

        // Redirect with 3 entries held
        do_reset(1'b0);
        repeat (3) tick();
        check("t4_occ3", 32'(bus.occupancy), 32'h3);
        redirect_to(32'h100);
        check("t4_valid0", 32'(bus.out_valid), 32'h0);
        check("t4_occ0", 32'(bus.occupancy), 32'h0);
        tick();
        check("t4_valid1", 32'(bus.out_valid), 32'h1);
        check("t4_pc100", bus.out_pc, 32'h100);
        bus.out_ready = 1'b1;
        tick();
        check("t4_pc104", bus.out_pc, 32'h104);

        // Back-to-back redirects with decode ready
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_pc    = 32'h300;
        tick();
        bus.redirect_valid = 1'b0;
        check("t5_valid0", 32'(bus.out_valid), 32'h0);
        tick();
        check("t5_pc300", bus.out_pc, 32'h300);
        tick();
        check("t5_pc304", bus.out_pc, 32'h304);

        // PC wrap and unaligned target
        redirect_to(32'hFFFF_FFFC);
        tick();
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", bus.out_pc_plus4, 32'h0);
        tick();
        check("wrap_next", bus.out_pc, 32'h0);
        redirect_to(32'h102);
        tick();
        check("unal_pc", bus.out_pc, 32'h102);
        tick();
        check("unal_next", bus.out_pc, 32'h106);
        check("no_200", 32'(seen200), 32'h0);

        // Asynchronous reset mid-cycle with 2 entries held
        do_reset(1'b0);
        repeat (2) tick();
        check("t6_occ2", 32'(bus.occupancy), 32'h2);
        #1;
        rst = 1'b0;
        #1;
        check("t6_valid", 32'(bus.out_valid), 32'h0);
        check("t6_occ", 32'(bus.occupancy), 32'h0);
`ifdef PREFETCH_PERF_EN
        check("t6_stall", bus.perf_stall_cycles, 32'h0);
        check("t6_flush", bus.perf_flushes, 32'h0);
`endif
        tick();
        rst = 1'b1;
        tick();
        check("t6_restart", bus.out_pc, 32'h0);
        check("t6_rvalid", 32'(bus.out_valid), 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
